dmem_mmio_bridge: RTL and testbench
===================================

Name: dmem_mmio_bridge

Overview:
Memory-stage bridge directly downstream of the pipelined core's data-memory port. It consumes the core's address, write-enable and write data, and returns read data with one-cycle latency into the writeback result path.
- Decodes each access to either the external data BRAM or an MMIO block.
- The MMIO block holds an LED register, a free-running cycle counter and a FIFO-buffered UART transmitter.

Parameters:
DMEM_AW, 10, BRAM word-address width (DMEM size = 2^DMEM_AW words)
CLKS_PER_BIT, 868, UART bit period in clk cycles (must be >= 2)
TX_FIFO_DEPTH, 4, UART TX byte FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_addr  in  32  byte address from core memory stage (ALU result)
m_we  in  1  store strobe from core memory stage
m_wdata  in  32  store data
m_rdata  out  32  load data to core, valid one cycle after m_addr
bram_addr  out  DMEM_AW  word address to data BRAM
bram_we  out  1  BRAM write enable
bram_wdata  out  32  BRAM write data
bram_rdata  in  32  BRAM read data (synchronous, 1-cycle latency)
led  out  8  LED register
uart_tx  out  1  UART serial output, idle high

Behaviour:
Address decode (combinational; m_addr[1:0] ignored, word access only):
- DMEM region: m_addr[31:28]==4'h0. Drives bram_addr=m_addr[DMEM_AW+1:2], bram_we=m_we, bram_wdata=m_wdata. Address bits above the region alias.
- MMIO region: m_addr[31:28]==4'h1. Register is selected by m_addr[3:2]:
  - 0x0 LED: RW, bits[7:0].
  - 0x4 CYCLE: RO, 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 0x8 TXDATA: WO; a write enqueues m_wdata[7:0]; reads return 0.
  - 0xC STATUS: read {27'b0, bus_err, tx_ovf, fifo_empty, fifo_full, tx_busy}. Any write clears tx_ovf and bus_err.
- Any other region: unmapped. Writes are dropped and set sticky bus_err; reads return 0.
- bram_we is 0 for every non-DMEM access.

Read path, 1-cycle latency, aligned to BRAM timing:
- sel_r (DMEM/MMIO/UNMAPPED) and mmio_rdata_r are registered each cycle.
- m_rdata = (sel_r==DMEM) ? bram_rdata : mmio_rdata_r.
- A read of CYCLE at cycle t returns the counter value sampled at edge t (the pre-increment value at t).

Store behaviour:
- An MMIO store also updates mmio_rdata_r with the old register value. The core ignores it.
- Store to DMEM: m_rdata on the next cycle is don't-care.

UART transmitter:
- Frame: start 0, 8 data bits LSB first, stop 1. Each bit is held CLKS_PER_BIT cycles; a bit counter counts 0..CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE->START when the FIFO is not empty: pop the byte into the shift register.
  - START->DATA after one bit period.
  - DATA->STOP after 8 bits.
  - STOP->IDLE after one bit period.
- Back-to-back frames: one IDLE cycle between frames.
- tx_busy = (state != IDLE).

TX FIFO:
- Write into a full FIFO: byte dropped, tx_ovf set.
- Pop and push in the same cycle while full: the pop frees space first, and the push is accepted.
- Push into an empty FIFO while IDLE: the byte is popped on the following cycle.
- Sticky set and clear-write in the same cycle: set wins.

Reset (async, active-high, any cycle including mid-frame):
- led=0, uart_tx=1, cycle=0, m_rdata=0 (sel_r=MMIO, mmio_rdata_r=0).
- FIFO empty, FSM IDLE, all sticky bits 0.
- BRAM contents are not reset.

Decomposition:
Package dmem_mmio_pkg holds:
- region base constants (DMEM_BASE 4'h0, MMIO_BASE 4'h1);
- MMIO offset constants (LED 2'd0, CYCLE 2'd1, TXDATA 2'd2, STATUS 2'd3);
- region-select enum {SEL_DMEM, SEL_MMIO, SEL_UNMAPPED};
- UART state enum {TX_IDLE, TX_START, TX_DATA, TX_STOP}.

Sub-module: mmio_uart_tx (FIFO + serializer). Its interface is push, push_data[7:0], full, empty and busy; overflow detection happens in the parent.

Test Plan:
1. Reset then store 0xCAFEF00D to 0x0000_0010 and load it back -> bram_addr=4, bram_we=1 for one cycle; m_rdata=0xCAFEF00D the cycle after the load address is presented.
2. Store 0x1A5 to 0x1000_0000, then load 0x1000_0000 -> led=0xA5; m_rdata=0x000000A5.
3. Load 0x1000_0004 twice, 5 cycles apart -> the second value minus the first equals 5; force the counter to 0xFFFFFFFF and confirm it wraps to 0.
4. With CLKS_PER_BIT=4, store 0x55 to 0x1000_0008 -> uart_tx is 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then 1. STATUS tx_busy=1 during the frame and 0 one cycle after the stop bit.
5. Write 6 bytes back-to-back with depth 4 -> the first is popped immediately, 4 are queued and the 6th is dropped. STATUS reads fifo_full=1 and tx_ovf=1; a write to STATUS clears tx_ovf.
6. Store to 0x2000_0000 -> bram_we stays 0, bus_err=1, and a load from that address returns 0. Assert reset mid-frame -> uart_tx=1 immediately and STATUS reads 0x4 (fifo_empty only).

Source files
------------

// File: rtl/dmem_mmio_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_pkg
// Description : Shared decode constants and enums for the data-memory / MMIO
//               bridge and its UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_mmio_pkg;

    localparam logic [3:0] DMEM_BASE = 4'h0;
    localparam logic [3:0] MMIO_BASE = 4'h1;

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_CYCLE  = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    typedef enum logic [1:0] {
        SEL_DMEM     = 2'd0,
        SEL_MMIO     = 2'd1,
        SEL_UNMAPPED = 2'd2
    } sel_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_bridge_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Byte FIFO feeding an 8N1 UART serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    output logic       full_o,
    output logic       empty_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;

    logic w_pop, w_push_ok, w_bit_end;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign busy_o    = (state_q != TX_IDLE);
    assign w_pop     = (state_q == TX_IDLE) && !empty_o;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = push_i && (!full_o || w_pop);
    assign w_bit_end = (bit_cnt_q == LAST_CNT);

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= TX_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = w_bit_end ? '0 : bit_cnt_q + BW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            TX_IDLE: begin
                bit_cnt_d = '0;
                if (w_pop) begin
                    state_d   = TX_START;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = '0;
                end
            end
            TX_START: if (w_bit_end) state_d = TX_DATA;
            TX_DATA: begin
                if (w_bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = TX_STOP;
                end
            end
            TX_STOP: if (w_bit_end) state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        case (state_q)
            TX_START: tx_o = 1'b0;
            TX_DATA:  tx_o = shift_q[0];
            default:  tx_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_bridge
// Description : Decodes core memory-stage accesses to data BRAM or MMIO
//               (LED, cycle counter, UART TX) with 1-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio_bridge
    import dmem_mmio_pkg::*;
#(
    parameter int DMEM_AW       = 10,
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        m_addr,
    input  logic               m_we,
    input  logic [31:0]        m_wdata,
    output logic [31:0]        m_rdata,
    output logic [DMEM_AW-1:0] bram_addr,
    output logic               bram_we,
    output logic [31:0]        bram_wdata,
    input  logic [31:0]        bram_rdata,
    output logic [7:0]         led,
    output logic               uart_tx
);

    sel_e        w_sel, sel_q;
    logic [1:0]  w_off;
    logic [7:0]  led_q, led_d;
    logic [31:0] cycle_q, cycle_d;
    logic        tx_ovf_q, tx_ovf_d, bus_err_q, bus_err_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    logic        w_mmio_we, w_tx_push, w_tx_pop, w_stat_clr;
    logic        w_full, w_empty, w_busy;
    logic [31:0] w_status;
    logic        w_unused;

    always_comb begin
        w_sel = SEL_UNMAPPED;
        if (m_addr[31:28] == DMEM_BASE)      w_sel = SEL_DMEM;
        else if (m_addr[31:28] == MMIO_BASE) w_sel = SEL_MMIO;
    end

    assign w_off      = m_addr[3:2];
    assign w_unused   = ^{m_addr[1:0], m_addr[27:DMEM_AW+2]};
    assign bram_addr  = m_addr[DMEM_AW+1:2];
    assign bram_we    = m_we && (w_sel == SEL_DMEM);
    assign bram_wdata = m_wdata;

    assign w_mmio_we  = m_we && (w_sel == SEL_MMIO);
    assign w_tx_push  = w_mmio_we && (w_off == OFF_TXDATA);
    assign w_stat_clr = w_mmio_we && (w_off == OFF_STATUS);
    // Mirrors the transmitter's pop condition so overflow is flagged only for truly dropped bytes.
    assign w_tx_pop   = !w_busy && !w_empty;
    assign w_status   = {27'b0, bus_err_q, tx_ovf_q, w_empty, w_full, w_busy};
    assign cycle_d    = cycle_q + 32'd1;

    always_comb begin
        led_d     = led_q;
        tx_ovf_d  = tx_ovf_q;
        bus_err_d = bus_err_q;
        if (w_mmio_we && (w_off == OFF_LED)) led_d = m_wdata[7:0];
        if (w_stat_clr) begin
            tx_ovf_d  = 1'b0;
            bus_err_d = 1'b0;
        end
        if (w_tx_push && w_full && !w_tx_pop)  tx_ovf_d  = 1'b1;
        if (m_we && (w_sel == SEL_UNMAPPED))   bus_err_d = 1'b1;
    end

    always_comb begin
        mmio_rdata_d = '0;
        if (w_sel == SEL_MMIO) begin
            case (w_off)
                OFF_LED:    mmio_rdata_d = {24'b0, led_q};
                OFF_CYCLE:  mmio_rdata_d = cycle_q;
                OFF_STATUS: mmio_rdata_d = w_status;
                default:    mmio_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q        <= '0;
            cycle_q      <= '0;
            tx_ovf_q     <= 1'b0;
            bus_err_q    <= 1'b0;
            sel_q        <= SEL_MMIO;
            mmio_rdata_q <= '0;
        end else begin
            led_q        <= led_d;
            cycle_q      <= cycle_d;
            tx_ovf_q     <= tx_ovf_d;
            bus_err_q    <= bus_err_d;
            sel_q        <= w_sel;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    assign m_rdata = (sel_q == SEL_DMEM) ? bram_rdata : mmio_rdata_q;
    assign led     = led_q;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DEPTH        (TX_FIFO_DEPTH)
    ) u_uart_tx (
        .clk         (clk),
        .reset       (reset),
        .push_i      (w_tx_push),
        .push_data_i (m_wdata[7:0]),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .busy_o      (w_busy),
        .tx_o        (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_mmio_bridge
// Description : Directed self-checking bench for dmem_mmio_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_mmio_bridge;

    localparam int DMEM_AW = 10;
    localparam logic [31:0] A_LED    = 32'h1000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h1000_0004;
    localparam logic [31:0] A_TXDATA = 32'h1000_0008;
    localparam logic [31:0] A_STATUS = 32'h1000_000C;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        m_addr = '0;
    logic               m_we = 1'b0;
    logic [31:0]        m_wdata = '0;
    logic [31:0]        m_rdata;
    logic [DMEM_AW-1:0] bram_addr;
    logic               bram_we;
    logic [31:0]        bram_wdata;
    logic [31:0]        bram_rdata = '0;
    logic [7:0]         led;
    logic               uart_tx;

    int checks = 0;
    int failures = 0;

    logic [31:0] bram_mem [1<<DMEM_AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_wdata;
        bram_rdata <= bram_mem[bram_addr];
    end

    dmem_mmio_bridge #(
        .DMEM_AW       (DMEM_AW),
        .CLKS_PER_BIT  (4),
        .TX_FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_addr     (m_addr),
        .m_we       (m_we),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .bram_addr  (bram_addr),
        .bram_we    (bram_we),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata),
        .led        (led),
        .uart_tx    (uart_tx)
    );

    task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
        @(negedge clk);
        m_addr = a; m_we = we; m_wdata = d;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; m_addr = A_CYCLE; m_we = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (led !== 8'h00) begin failures++; $display("FAIL reset_led: got %h expected 00", led); end
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
        reset = 1'b0;
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL reset_cycle0: got %h expected 0", m_rdata); end
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h4) begin failures++; $display("FAIL reset_status: got %h expected 4", m_rdata); end
    endtask

    task automatic test_dmem;
        drive(32'h0000_0010, 1'b1, 32'hCAFE_F00D);
        checks++; if (bram_addr !== 10'd4 || bram_we !== 1'b1) begin failures++; $display("FAIL dmem_store: got addr %0d we %b expected addr 4 we 1", bram_addr, bram_we); end
        drive(32'h0000_0010, 1'b0, 32'h0);
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL dmem_we_pulse: got %b expected 0", bram_we); end
        drive(32'h0000_1014, 1'b1, 32'h1234_5678);
        checks++; if (m_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL dmem_load: got %h expected cafef00d", m_rdata); end
        checks++; if (bram_addr !== 10'd5) begin failures++; $display("FAIL dmem_alias: got %0d expected 5", bram_addr); end
        drive(32'h0000_0014, 1'b0, 32'h0);
        drive(32'h0000_0014, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h1234_5678) begin failures++; $display("FAIL dmem_alias_load: got %h expected 12345678", m_rdata); end
    endtask

    task automatic test_led;
        drive(A_LED, 1'b1, 32'h0000_01A5);
        drive(A_LED, 1'b0, 32'h0);
        checks++; if (led !== 8'hA5) begin failures++; $display("FAIL led_out: got %h expected a5", led); end
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL led_store_old: got %h expected 0", m_rdata); end
        drive(A_TXDATA, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h0000_00A5) begin failures++; $display("FAIL led_load: got %h expected a5", m_rdata); end
        drive(A_LED, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h expected 0", m_rdata); end
    endtask

    task automatic test_cycle;
        logic [31:0] v1, v2;
        drive(A_CYCLE, 1'b0, 32'h0);
        drive(A_CYCLE, 1'b0, 32'h0);
        v1 = m_rdata;
        repeat (5) drive(A_CYCLE, 1'b0, 32'h0);
        v2 = m_rdata;
        checks++; if (v2 - v1 !== 32'd5) begin failures++; $display("FAIL cycle_delta: got %0d expected 5", v2 - v1); end
        @(negedge clk);
        force dut.cycle_d = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cycle_d;
        @(negedge clk); #1;
        checks++; if (m_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_max: got %h expected ffffffff", m_rdata); end
        @(negedge clk); #1;
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL cycle_wrap: got %h expected 0", m_rdata); end
    endtask

    task automatic test_uart_frame;
        logic [7:0]  byte_v;
        logic        exp_tx;
        logic [31:0] exp_st;
        byte_v = 8'h55;
        drive(A_TXDATA, 1'b1, 32'h0000_0055);
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL uart_pre_idle: got %b expected 1", uart_tx); end
        for (int k = 2; k <= 43; k++) begin
            @(negedge clk); #1;
            if (k <= 5)       exp_tx = 1'b0;
            else if (k <= 37) exp_tx = byte_v[(k - 6) / 4];
            else              exp_tx = 1'b1;
            if (k == 2)       exp_st = 32'h0;
            else if (k <= 42) exp_st = 32'h5;
            else              exp_st = 32'h4;
            checks++; if (uart_tx !== exp_tx) begin failures++; $display("FAIL uart_bit k=%0d: got %b expected %b", k, uart_tx, exp_tx); end
            checks++; if (m_rdata !== exp_st) begin failures++; $display("FAIL uart_status k=%0d: got %h expected %h", k, m_rdata, exp_st); end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) drive(A_TXDATA, 1'b1, 32'h10 + i);
        drive(A_STATUS, 1'b0, 32'h0);
        drive(A_STATUS, 1'b1, 32'h0);
        checks++; if (m_rdata !== 32'h0B) begin failures++; $display("FAIL fifo_full_ovf: got %h expected 0b", m_rdata); end
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h0B) begin failures++; $display("FAIL ovf_clear_write_rdata: got %h expected 0b", m_rdata); end
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h03) begin failures++; $display("FAIL ovf_cleared: got %h expected 03", m_rdata); end
    endtask

    task automatic test_unmapped;
        drive(32'h2000_0000, 1'b1, 32'hDEAD_BEEF);
        checks++; if (bram_we !== 1'b0) begin failures++; $display("FAIL unmapped_we: got %b expected 0", bram_we); end
        drive(32'h2000_0000, 1'b0, 32'h0);
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if (m_rdata !== 32'h0) begin failures++; $display("FAIL unmapped_load: got %h expected 0", m_rdata); end
        drive(A_STATUS, 1'b0, 32'h0);
        checks++; if ((m_rdata & 32'h18) !== 32'h10) begin failures++; $display("FAIL bus_err: got %h expected bit4 set bit3 clear", m_rdata); end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        checks++; if (n >= 400) begin failures++; $display("FAIL midframe_wait: got timeout expected start bit"); end
        reset = 1'b1;
        #1;
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL midframe_tx: got %b expected 1", uart_tx); end
        checks++; if (m_rdata !== 32'h0 || led !== 8'h00) begin failures++; $display("FAIL midframe_regs: got rdata %h led %h expected 0 00", m_rdata, led); end
        @(negedge clk);
        reset = 1'b0; m_addr = A_STATUS; m_we = 1'b0;
        @(negedge clk); #1;
        checks++; if (m_rdata !== 32'h4) begin failures++; $display("FAIL midframe_status: got %h expected 4", m_rdata); end
    endtask

    initial begin
        test_reset;
        test_dmem;
        test_led;
        test_cycle;
        test_uart_frame;
        test_back_to_back;
        test_unmapped;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
